gcd_ctrl: RTL and testbench
===========================

# gcd_ctrl

Sequencing controller for the 12-bit GCD operation selected by `sel = 6'b101000`. It detects a rising edge on the `carryin` pushbutton while that operation is selected and latches the two keypad operands. It then runs Euclid's algorithm by repeated subtraction, one step per clock, and presents the result, a step count, and status to the LCD text path. It sits beside the ALU in the top level, and its result replaces the ALU output on the LCD whenever the GCD opcode is selected.

## Interface
- `WIDTH`, 12, operand/result width
- `GCD_SEL`, 6'b101000, opcode that enables this block
- `lcdclk`  in  1  system clock
- `resetn`  in  1  reset; asynchronous, active-high (the codebase port name is kept; the polarity is fixed)
- `sel`  in  6  operation select from switches
- `carryin`  in  1  start pushbutton, raw level, asynchronous to `lcdclk`
- `a_in`  in  WIDTH  operand A (keypad value A)
- `b_in`  in  WIDTH  operand B (keypad value B)
- `gcd_out`  out  WIDTH  result; holds the last completed value
- `steps`  out  WIDTH  number of subtraction steps in the last/current run
- `busy`  out  1  high while computing
- `done`  out  1  one-cycle pulse when the result becomes valid
- `err`  out  1  high when the last run had A=B=0; cleared at the next accepted start

## Operation
- **Start detect.** `carryin` passes through two flops, `s1` then `s2`. `start_edge = s1 & ~s2`.
- **Start accept.** A start is accepted when `start_edge` is high, `sel == GCD_SEL`, and the state is IDLE or DONE.
- **States.** The FSM has three states: IDLE, RUN and DONE.
- **IDLE/DONE → RUN, on accept.**
  - A ← `a_in`, B ← `b_in`.
  - `steps` ← 0, `err` ← 0, `busy` ← 1.
- **RUN, evaluated every cycle, first matching rule wins:**
  1. `sel != GCD_SEL`: abort to IDLE. `busy` ← 0, no `done` pulse, `gcd_out` and `err` unchanged, `steps` frozen.
  2. A==0 and B==0: `gcd_out` ← 0, `err` ← 1, go to DONE.
  3. A==0 or B==0: `gcd_out` ← A|B, go to DONE.
  4. A==B: `gcd_out` ← A, go to DONE.
  5. A>B: A ← A−B, `steps` ← `steps`+1.
  6. Otherwise: B ← B−A, `steps` ← `steps`+1.
- **Entering DONE.** `busy` ← 0 and `done` ← 1 for exactly one cycle. DONE then holds all outputs.
- **Width rules.**
  - All comparisons are unsigned on WIDTH bits.
  - Subtraction never underflows, because the larger operand is always the minuend.
  - `steps` cannot overflow: the worst case is 4095,1, which needs 4094 steps.
- **Ignored inputs.**
  - Start edges while in RUN are ignored and are not queued.
  - Changes to `a_in`/`b_in` during RUN have no effect.
- **Pushbutton level.** Holding `carryin` high starts only one run.

## Timing
- **Reset.**
  - The state goes to IDLE.
  - A, B, `gcd_out`, `steps`, `s1` and `s2` are 0.
  - `busy`, `done` and `err` are 0.
- **Reset mid-run.** Reset takes effect immediately, with no `done` pulse.
- **Start latency.** Let edge E0 be the clock edge that samples the accept condition.
  - `busy` = 1 after E0.
  - The raw `carryin` rise reaches `start_edge` 2 edges later because of the synchronizer.
- **Result latency.** With N subtraction steps, the final rule (2, 3 or 4) evaluates at edge E0+N+1.
  - `gcd_out`, `done`=1 and `busy`=0 are all visible after edge E0+N+1.
  - `done` drops after edge E0+N+2.
- **Throughput.** A new start can be accepted in the first DONE cycle, which is the same cycle `done` is high.
- **Outputs.** All outputs are registered; no combinational paths run from inputs to outputs.

## Test plan
- **Basic run.** Reset, `sel`=101000, A=12, B=8, pulse `carryin` → N=2 steps (12,8 → 4,8 → 4,4). `gcd_out`=4, `steps`=2, `done` high for exactly 1 cycle at E0+3, `err`=0.
- **Worst case.** A=4095, B=1 → `busy` for 4095 cycles, `gcd_out`=1, `steps`=4094, then one `done` pulse.
- **Zero operands.**
  - A=0, B=9 → `gcd_out`=9, `steps`=0, `done` at E0+1, `err`=0.
  - A=0, B=0 → `gcd_out`=0, `err`=1.
  - A following start with A=6, B=4 → `err` cleared to 0, `gcd_out`=2.
- **Abort.** Start A=4095, B=1, then change `sel` to 000000 after 10 cycles → `busy` falls the next cycle, no `done`, `gcd_out` keeps its previous value, `steps`=10 (frozen).
- **Start filtering.**
  - `carryin` held high for 100 cycles → exactly one run.
  - A second `carryin` pulse during RUN → ignored; only one `done`.
  - A `carryin` pulse with `sel`=000001 → no start.
- **Async reset.** Assert `resetn` mid-RUN, between clock edges → all outputs go to 0 immediately. After release, a fresh start with A=18, B=12 → `gcd_out`=6, `steps`=2.

Source files
------------

// File: rtl/gcd_ctrl_if.sv
// gcd_ctrl_if: operand, select and result bundle between the GCD sequencer
// and its surroundings (switches/keypad on one side, LCD text path on the other).
//   sel      operation select from switches
//   carryin  raw start pushbutton level (asynchronous to the clock)
//   a_in     operand A, b_in operand B
//   gcd_out  last completed result
//   steps    subtraction steps of the last/current run
//   busy     computing, done one-cycle completion pulse, err A=B=0 run
// master drives the inputs and observes results; slave is the sequencer.
interface gcd_ctrl_if #(
  parameter int WIDTH = 12
);
  logic [5:0]       sel;
  logic             carryin;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] gcd_out;
  logic [WIDTH-1:0] steps;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output sel, carryin, a_in, b_in,
    input  gcd_out, steps, busy, done, err
  );

  modport slave (
    input  sel, carryin, a_in, b_in,
    output gcd_out, steps, busy, done, err
  );
endinterface

// File: rtl/gcd_ctrl.sv
// gcd_ctrl: sequencing controller for the GCD opcode. Synchronizes the start
// pushbutton, accepts a start on its rising edge while the GCD opcode is
// selected, latches both operands and runs Euclid's algorithm by repeated
// subtraction, one step per clock. Result, step count and status are held
// for the LCD text path.
// Ports:
//   lcdclk  system clock
//   resetn  asynchronous reset, active-high (legacy name)
//   bus     gcd_ctrl_if slave: sel/carryin/a_in/b_in in,
//           gcd_out/steps/busy/done/err out (all registered)
module gcd_ctrl #(
  parameter int         WIDTH   = 12,
  parameter logic [5:0] GCD_SEL = 6'b101000
) (
  input  logic        lcdclk,
  input  logic        resetn,
  gcd_ctrl_if.slave   bus
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic [WIDTH-1:0] steps_q, steps_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             s1_q, s2_q;

  logic             start_edge_s;
  logic             sel_ok_s;
  logic             accept_s;

  assign start_edge_s = s1_q & ~s2_q;
  assign sel_ok_s     = (bus.sel == GCD_SEL);
  // A new run may begin in the very cycle done is pulsing.
  assign accept_s     = start_edge_s & sel_ok_s &
                        ((state_q == ST_IDLE) | (state_q == ST_DONE));

  // Two-flop synchronizer on the raw pushbutton level.
  always_ff @(posedge lcdclk or posedge resetn) begin
    if (resetn) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= bus.carryin;
      s2_q <= s1_q;
    end
  end

  // Next-state and datapath decisions; rule order inside RUN is priority order.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
    steps_d = steps_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          state_d = ST_RUN;
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          steps_d = {WIDTH{1'b0}};
          err_d   = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (!sel_ok_s) begin
          // Abort: result and error keep their previous run's values.
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if ((a_q == {WIDTH{1'b0}}) && (b_q == {WIDTH{1'b0}})) begin
          state_d = ST_DONE;
          gcd_d   = {WIDTH{1'b0}};
          err_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if ((a_q == {WIDTH{1'b0}}) || (b_q == {WIDTH{1'b0}})) begin
          state_d = ST_DONE;
          gcd_d   = a_q | b_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (a_q == b_q) begin
          state_d = ST_DONE;
          gcd_d   = a_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (a_q > b_q) begin
          a_d     = a_q - b_q;
          steps_d = steps_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          b_d     = b_q - a_q;
          steps_d = steps_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Controller and output registers.
  always_ff @(posedge lcdclk or posedge resetn) begin
    if (resetn) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      gcd_q   <= {WIDTH{1'b0}};
      steps_q <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
      steps_q <= steps_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.gcd_out = gcd_q;
  assign bus.steps   = steps_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Scoreboard bench for gcd_ctrl: starts push expected results; a monitor
// pops and compares on every done pulse.
module tb_gcd_ctrl;
  localparam int         W   = 12;
  localparam logic [5:0] SEL = 6'b101000;

  logic lcdclk = 1'b0;
  logic resetn = 1'b1;

  gcd_ctrl_if #(.WIDTH(W)) bus ();

  gcd_ctrl #(.WIDTH(W), .GCD_SEL(SEL)) dut (
    .lcdclk (lcdclk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 lcdclk = ~lcdclk;

  typedef struct {
    int g;
    int st;
    bit e;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp     = 0;
  int   n_bad     = 0;
  int   done_seen = 0;
  int   pushed    = 0;
  int   last_gcd  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: Euclid by division; the subtraction count is the sum of the
  // quotients, less the final subtraction that would reach zero.
  function automatic exp_t ref_gcd(input int a, input int b);
    exp_t r;
    int x, y, t, s;
    r.e = 1'b0;
    if (a == 0 && b == 0) begin
      r.g = 0; r.st = 0; r.e = 1'b1;
    end else if (a == 0 || b == 0) begin
      r.g = a | b; r.st = 0;
    end else begin
      x = a; y = b; s = 0;
      while (y != 0) begin
        s += x / y;
        t = x % y;
        x = y;
        y = t;
      end
      r.g = x; r.st = s - 1;
    end
    return r;
  endfunction

  // Monitor: on each done pulse compare against the oldest expectation.
  initial begin
    int   busy_cnt;
    bit   prev_done;
    exp_t e;
    busy_cnt  = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge lcdclk);
      if (bus.done) begin
        chk("done_width", int'(prev_done), 0);
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1, expected no pending run (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          chk("gcd_out", int'(bus.gcd_out), e.g);
          chk("steps", int'(bus.steps), e.st);
          chk("err", int'(bus.err), int'(e.e));
          chk("latency", busy_cnt, e.st + 1);
          chk("busy_at_done", int'(bus.busy), 0);
        end
        done_seen++;
        busy_cnt = 0;
      end else if (bus.busy) begin
        busy_cnt++;
      end else begin
        busy_cnt = 0;
      end
      prev_done = bus.done;
    end
  end

  // Raise carryin for 'hold' cycles; report whether busy was seen.
  task automatic start_run(input int a, input int b, input int hold,
                           input bit push, output bit seen);
    int   cyc;
    exp_t r;
    @(negedge lcdclk);
    bus.a_in    = W'(a);
    bus.b_in    = W'(b);
    bus.carryin = 1'b1;
    if (push) begin
      r = ref_gcd(a, b);
      sb_q.push_back(r);
      pushed++;
      last_gcd = r.g;
    end
    cyc  = 0;
    seen = 1'b0;
    while (1) begin
      @(negedge lcdclk);
      cyc++;
      if (bus.busy) seen = 1'b1;
      if (cyc >= hold) bus.carryin = 1'b0;
      if (cyc >= hold && seen) break;
      if (cyc >= hold + 10) break;
    end
  endtask

  task automatic wait_done(input int target);
    int cnt;
    cnt = 0;
    while (done_seen < target && cnt < 6000) begin
      @(negedge lcdclk);
      cnt++;
    end
    if (done_seen < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got %0d dones, expected %0d", done_seen, target);
    end
  endtask

  task automatic run_check(input int a, input int b, input int hold);
    bit seen;
    start_run(a, b, hold, 1'b1, seen);
    chk("started", int'(seen), 1);
    wait_done(pushed);
  endtask

  initial begin
    bit   seen;
    int   a, b, d0;
    exp_t r;
    bus.sel     = SEL;
    bus.carryin = 1'b0;
    bus.a_in    = '0;
    bus.b_in    = '0;

    // Reset state
    repeat (3) @(negedge lcdclk);
    resetn = 1'b0;
    @(negedge lcdclk);
    chk("rst_gcd", int'(bus.gcd_out), 0);
    chk("rst_steps", int'(bus.steps), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);

    // Directed runs
    run_check(12, 8, 1);
    run_check(0, 9, 1);
    run_check(0, 0, 1);
    run_check(6, 4, 1);
    run_check(4095, 1, 1);

    // Abort after 10 steps
    start_run(4095, 1, 1, 1'b0, seen);
    chk("abort_started", int'(seen), 1);
    d0 = done_seen;
    repeat (10) @(negedge lcdclk);
    bus.sel = 6'b000000;
    @(negedge lcdclk);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_steps", int'(bus.steps), 10);
    chk("abort_gcd", int'(bus.gcd_out), last_gcd);
    chk("abort_err", int'(bus.err), 0);
    repeat (5) @(negedge lcdclk);
    chk("abort_no_done", done_seen, d0);
    bus.sel = SEL;

    // Held pushbutton starts one run only
    run_check(30, 18, 100);
    repeat (10) @(negedge lcdclk);

    // Second pulse during RUN is ignored, operand changes too
    start_run(200, 3, 1, 1'b1, seen);
    chk("started", int'(seen), 1);
    @(negedge lcdclk);
    bus.carryin = 1'b1;
    bus.a_in    = W'(77);
    bus.b_in    = W'(5);
    @(negedge lcdclk);
    bus.carryin = 1'b0;
    wait_done(pushed);
    repeat (10) @(negedge lcdclk);

    // Wrong opcode: no start
    bus.sel = 6'b000001;
    d0 = done_seen;
    start_run(40, 10, 1, 1'b0, seen);
    chk("sel_filter_busy", int'(seen), 0);
    chk("sel_filter_done", done_seen, d0);
    bus.sel = SEL;

    // Asynchronous reset mid-run
    start_run(4095, 1, 1, 1'b0, seen);
    chk("arst_started", int'(seen), 1);
    repeat (20) @(negedge lcdclk);
    #2 resetn = 1'b1;
    #1;
    chk("arst_gcd", int'(bus.gcd_out), 0);
    chk("arst_steps", int'(bus.steps), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_done", int'(bus.done), 0);
    chk("arst_err", int'(bus.err), 0);
    @(negedge lcdclk);
    resetn = 1'b0;
    run_check(18, 12, 1);

    // Randomized runs with in-run disturbances
    for (int i = 0; i < 25; i++) begin
      a = int'($urandom_range(0, 300));
      b = int'($urandom_range(0, 300));
      if ($urandom_range(0, 7) == 0) a = 0;
      if ($urandom_range(0, 7) == 0) b = 0;
      r = ref_gcd(a, b);
      start_run(a, b, 1, 1'b1, seen);
      chk("rand_started", int'(seen), 1);
      if (r.st >= 8) begin
        @(negedge lcdclk);
        bus.carryin = 1'b1;
        bus.a_in    = W'($urandom_range(0, 4095));
        bus.b_in    = W'($urandom_range(0, 4095));
        @(negedge lcdclk);
        bus.carryin = 1'b0;
      end
      wait_done(pushed);
    end

    repeat (5) @(negedge lcdclk);
    chk("queue_empty", sb_q.size(), 0);
    chk("done_count", done_seen, pushed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
